// File: rtl/freq_meter_pkg.sv
// Shared widths, FSM state encodings and dividend helper for the tuner frequency meters.
package freq_meter_pkg;

  localparam int unsigned DIV_W = 32;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned ST_W  = 2;

  localparam logic [1:0] ST_SEEK    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DIVIDE  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Samples per second times periods per measurement; quotient by sample count gives Hz.
  function automatic logic [DIV_W-1:0] calc_dividend(input int unsigned rate,
                                                     input int unsigned periods);
    return DIV_W'(rate * periods);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; divisor 0 yields all-ones quotient.
module serial_divider
  import freq_meter_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic         busy,
  output logic [W-1:0] quotient
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W:0]    shifted_c;
  logic          ge_c;

  assign shifted_c = {rem, quotient[W-1]};
  assign ge_c      = shifted_c >= {1'b0, dvs};

  // Dividend bits shift out of the quotient register as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        dvs      <= divisor;
        quotient <= dividend;
        cnt      <= CW'(W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (ge_c) rem <= W'(shifted_c - {1'b0, dvs});
        else      rem <= shifted_c[W-1:0];
        quotient <= {quotient[W-2:0], ge_c};
        cnt      <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/zero_cross_freq_meter.sv
// Codec ADC reader: hysteretic rising zero-crossing counter with serial divide to Hz.
// Build option FREQ_AVG_EN: average each new result with the previous one.
module zero_cross_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 24,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned PERIODS     = 4,
  parameter int unsigned HYST        = 4096,
  parameter int unsigned TIMEOUT     = 4800,
  parameter int unsigned FREQ_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_ready,
  input  logic [SAMPLE_W-1:0] readdata,
  output logic                read,
  output logic [FREQ_W-1:0]   freq,
  output logic                freq_valid,
  output logic                busy
);

  localparam int unsigned X_W = $clog2(PERIODS + 1);
  localparam logic [DIV_W-1:0] DIVIDEND = calc_dividend(SAMPLE_RATE, PERIODS);
  localparam logic signed [SAMPLE_W-1:0] POS_TH = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] NEG_TH = -POS_TH;

  logic [ST_W-1:0]             state_q, state_d;
  logic                        armed;
  logic [CNT_W-1:0]            samp_cnt, idle_cnt;
  logic [X_W-1:0]              xcnt;
  logic signed [SAMPLE_W-1:0]  sample_c;
  logic                        accept_c, cross_c, last_cross_c, timeout_c, hunting_c;
  logic [CNT_W-1:0]            samp_inc_c, idle_inc_c;
  logic [X_W-1:0]              xcnt_inc_c;
  logic                        div_done;
  logic [DIV_W-1:0]            div_quot;
  logic [FREQ_W-1:0]           q_sat_c, result_c;

  assign accept_c     = read_ready & ~read;
  assign sample_c     = $signed(readdata);
  assign cross_c      = accept_c & armed & (sample_c >= POS_TH);
  assign samp_inc_c   = samp_cnt + CNT_W'(1);
  assign idle_inc_c   = idle_cnt + CNT_W'(1);
  assign xcnt_inc_c   = xcnt + X_W'(1);
  assign hunting_c    = (state_q == ST_SEEK) || (state_q == ST_MEASURE);
  assign last_cross_c = (state_q == ST_MEASURE) && cross_c && (xcnt_inc_c == X_W'(PERIODS));
  // A crossing on the timeout sample wins over the timeout.
  assign timeout_c    = accept_c & ~cross_c & hunting_c & (idle_inc_c >= CNT_W'(TIMEOUT));

  serial_divider #(.W(DIV_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (last_cross_c),
    .dividend (DIVIDEND),
    .divisor  (DIV_W'(samp_inc_c)),
    .done     (div_done),
    .busy     (busy),
    .quotient (div_quot)
  );

  assign q_sat_c = (|div_quot[DIV_W-1:FREQ_W]) ? '1 : div_quot[FREQ_W-1:0];

`ifdef FREQ_AVG_EN
  logic              have_prev;
  logic [FREQ_W:0]   sum_c;
  assign sum_c    = {1'b0, freq} + {1'b0, q_sat_c};
  assign result_c = have_prev ? FREQ_W'(sum_c >> 1) : q_sat_c;

  // Averaging restarts from scratch after reset or a 0 Hz timeout.
  always_ff @(posedge clk) begin
    if (reset)                                 have_prev <= 1'b0;
    else if (timeout_c)                        have_prev <= 1'b0;
    else if (state_q == ST_DIVIDE && div_done) have_prev <= 1'b1;
  end
`else
  assign result_c = q_sat_c;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_SEEK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEEK:    if (cross_c) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (last_cross_c)   state_d = ST_DIVIDE;
        else if (timeout_c) state_d = ST_SEEK;
      end
      ST_DIVIDE:  if (div_done) state_d = ST_DONE;
      ST_DONE:    state_d = ST_SEEK;
      default:    state_d = ST_SEEK;
    endcase
  end

  // Handshake, detector, counters and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      read       <= 1'b0;
      armed      <= 1'b0;
      samp_cnt   <= '0;
      idle_cnt   <= '0;
      xcnt       <= '0;
      freq       <= '0;
      freq_valid <= 1'b0;
    end else begin
      read       <= accept_c;
      freq_valid <= 1'b0;
      if (accept_c) begin
        if (sample_c < NEG_TH) armed <= 1'b1;
        else if (cross_c)      armed <= 1'b0;
      end
      if (timeout_c) begin
        idle_cnt   <= '0;
        samp_cnt   <= '0;
        xcnt       <= '0;
        freq       <= '0;
        freq_valid <= 1'b1;
      end else begin
        if (accept_c) idle_cnt <= cross_c ? '0 : idle_inc_c;
        if (state_q == ST_SEEK && cross_c) begin
          samp_cnt <= '0;
          xcnt     <= '0;
        end
        if (state_q == ST_MEASURE) begin
          if (accept_c) samp_cnt <= samp_inc_c;
          if (cross_c)  xcnt     <= xcnt_inc_c;
        end
      end
      if (state_q == ST_DIVIDE && div_done) begin
        freq       <= result_c;
        freq_valid <= 1'b1;
      end
    end
  end

endmodule
